// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor, one digit per clock, least significant digit first.
// Subtraction adds the nines complement of B with an inverted borrow as the carry-in.
module bcd_serial_addsub #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  input  logic                  sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  err
);

  localparam int unsigned W    = 4 * DIGITS;
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DIGITS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    acc_q, acc_d;
  logic            carry_q, carry_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            err_acc_q, err_acc_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            err_q, err_d;

  logic [W-1:0]    b_nines;
  logic [3:0]      a_k, b_k, digit;
  logic [4:0]      t;
  logic            carry_nxt;

  always_comb begin
    b_nines = '0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      b_nines[k*4 +: 4] = 4'd9 - b[k*4 +: 4];
    end
  end

  // A stored nines-complement digit is >9 exactly when the original digit was,
  // so the error check works on b_q in both modes.
  always_comb begin
    a_k       = a_q[idx_q*4 +: 4];
    b_k       = b_q[idx_q*4 +: 4];
    t         = {1'b0, a_k} + {1'b0, b_k} + {4'd0, carry_q};
    digit     = t[3:0];
    carry_nxt = 1'b0;
    if (t > 5'd9) begin
      digit     = t[3:0] + 4'd6;
      carry_nxt = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    carry_d   = carry_q;
    idx_d     = idx_q;
    err_acc_d = err_acc_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    err_d     = err_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d       = a;
          b_d       = sub ? b_nines : b;
          carry_d   = sub ? ~cin : cin;
          idx_d     = '0;
          err_acc_d = 1'b0;
          acc_d     = '0;
          state_d   = StRun;
        end
      end
      StRun: begin
        acc_d[idx_q*4 +: 4] = digit;
        carry_d             = carry_nxt;
        err_acc_d           = err_acc_q | (a_k > 4'd9) | (b_k > 4'd9);
        if (idx_q == LastIdx) begin
          state_d = StDone;
          sum_d   = acc_d;
          cout_d  = carry_nxt;
          err_d   = err_acc_d;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      carry_q   <= 1'b0;
      idx_q     <= '0;
      err_acc_q <= 1'b0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      carry_q   <= carry_d;
      idx_q     <= idx_d;
      err_acc_q <= err_acc_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      err_q     <= err_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Directed bench for the 4-digit configuration plus randomised 1- and 8-digit runs
// checked against a decimal reference model.
`timescale 1ns/1ps
module tb_bcd_serial_addsub;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        in_valid4, in_ready4, cin4, sub4, out_valid4, out_ready4, cout4, err4;
  logic [15:0] a4, b4, sum4;

  logic        in_valid1, in_ready1, cin1, sub1, out_valid1, cout1, err1;
  logic [3:0]  a1, b1, sum1;

  logic        in_valid8, in_ready8, cin8, sub8, out_valid8, cout8, err8;
  logic [31:0] a8, b8, sum8;

  bcd_serial_addsub #(.DIGITS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .b(b4),
    .cin(cin4), .sub(sub4), .out_valid(out_valid4), .out_ready(out_ready4), .sum(sum4),
    .cout(cout4), .err(err4)
  );

  bcd_serial_addsub #(.DIGITS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1),
    .cin(cin1), .sub(sub1), .out_valid(out_valid1), .out_ready(1'b1), .sum(sum1),
    .cout(cout1), .err(err1)
  );

  bcd_serial_addsub #(.DIGITS(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
    .cin(cin8), .sub(sub8), .out_valid(out_valid8), .out_ready(1'b1), .sum(sum8),
    .cout(cout8), .err(err8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [31:0] ta, input logic [31:0] tb, input int nd,
                                input logic tcin, input logic tsub,
                                output logic [31:0] s, output logic co);
    longint av = 0, bv = 0, m = 1, r, ci;
    ci = tcin ? 1 : 0;
    for (int k = nd - 1; k >= 0; k--) begin
      av = av * 10 + longint'(ta[k*4 +: 4]);
      bv = bv * 10 + longint'(tb[k*4 +: 4]);
      m  = m * 10;
    end
    r  = tsub ? (av - bv - ci) : (av + bv + ci);
    co = tsub ? (r >= 0) : (r >= m);
    if (r < 0) r = r + m;
    r = r % m;
    s = '0;
    for (int k = 0; k < nd; k++) begin
      s[k*4 +: 4] = 4'(r % 10);
      r = r / 10;
    end
  endfunction

  task automatic run4(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                      input logic tcin, input logic tsub, input logic [15:0] esum,
                      input logic ecout, input logic eerr, input bit chk_sum, input int hold);
    int lat;
    @(negedge clk);
    chk({tag, " in_ready"}, in_ready4, 1);
    a4 = ta; b4 = tb; cin4 = tcin; sub4 = tsub; in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0; a4 = 16'hFFFF; b4 = 16'hFFFF; cin4 = ~tcin; sub4 = ~tsub;
    lat = 0;
    while (!out_valid4 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, lat, 4);
    if (chk_sum) chk({tag, " sum"}, sum4, esum);
    chk({tag, " cout"}, cout4, ecout);
    chk({tag, " err"}, err4, eerr);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid4 = ~in_valid4;
      a4 = 16'h1111; b4 = 16'h2222;
      chk({tag, " hold in_ready"}, in_ready4, 0);
      chk({tag, " hold out_valid"}, out_valid4, 1);
      chk({tag, " hold sum"}, sum4, esum);
      chk({tag, " hold cout"}, cout4, ecout);
      chk({tag, " hold err"}, err4, eerr);
    end
    @(negedge clk);
    in_valid4 = 1'b0; out_ready4 = 1'b1;
    @(posedge clk); #1;
    out_ready4 = 1'b0;
    chk({tag, " post out_valid"}, out_valid4, 0);
    chk({tag, " post in_ready"}, in_ready4, 1);
    if (chk_sum) chk({tag, " post sum"}, sum4, esum);
  endtask

  task automatic rand_pair(input int n);
    logic [31:0] ea1, ea8, r1, r8;
    logic        eco1, eco8, c1, c8, e1, e8;
    int          cyc, lat1, lat8;
    bit          got1, got8;
    for (int it = 0; it < n; it++) begin
      a1 = 4'($urandom_range(0, 9)); b1 = 4'($urandom_range(0, 9));
      for (int k = 0; k < 8; k++) begin
        a8[k*4 +: 4] = 4'($urandom_range(0, 9));
        b8[k*4 +: 4] = 4'($urandom_range(0, 9));
      end
      cin1 = 1'($urandom_range(0, 1)); sub1 = 1'($urandom_range(0, 1));
      cin8 = 1'($urandom_range(0, 1)); sub8 = 1'($urandom_range(0, 1));
      model({28'd0, a1}, {28'd0, b1}, 1, cin1, sub1, ea1, eco1);
      model(a8, b8, 8, cin8, sub8, ea8, eco8);
      @(posedge clk);
      @(negedge clk);
      chk("r1 in_ready", in_ready1, 1);
      chk("r8 in_ready", in_ready8, 1);
      in_valid1 = 1'b1; in_valid8 = 1'b1;
      @(posedge clk); #1;
      in_valid1 = 1'b0; in_valid8 = 1'b0;
      a1 = 4'hF; a8 = 32'hFFFF_FFFF;
      got1 = 0; got8 = 0; cyc = 0; lat1 = 0; lat8 = 0;
      r1 = '0; r8 = '0; c1 = 0; c8 = 0; e1 = 1; e8 = 1;
      while (!(got1 && got8) && cyc < 20) begin
        @(posedge clk); #1;
        cyc++;
        if (out_valid1 && !got1) begin
          got1 = 1; lat1 = cyc; r1 = {28'd0, sum1}; c1 = cout1; e1 = err1;
        end
        if (out_valid8 && !got8) begin
          got8 = 1; lat8 = cyc; r8 = sum8; c8 = cout8; e8 = err8;
        end
      end
      chk("r1 latency", lat1, 1);
      chk("r8 latency", lat8, 8);
      chk("r1 sum", r1, ea1);
      chk("r8 sum", r8, ea8);
      chk("r1 cout", c1, eco1);
      chk("r8 cout", c8, eco8);
      chk("r1 err", e1, 0);
      chk("r8 err", e8, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid4 = 0; out_ready4 = 0; a4 = '0; b4 = '0; cin4 = 0; sub4 = 0;
    in_valid1 = 0; a1 = '0; b1 = '0; cin1 = 0; sub1 = 0;
    in_valid8 = 0; a8 = '0; b8 = '0; cin8 = 0; sub8 = 0;
    #12;
    chk("reset out_valid", out_valid4, 0);
    chk("reset in_ready", in_ready4, 1);
    chk("reset sum", sum4, 0);
    chk("reset cout", cout4, 0);
    chk("reset err", err4, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run4("t1",  16'h0012, 16'h0005, 0, 0, 16'h0017, 0, 0, 1, 0);
    run4("t2a", 16'h9999, 16'h0001, 0, 0, 16'h0000, 1, 0, 1, 0);
    run4("t2b", 16'h0019, 16'h0009, 1, 0, 16'h0029, 0, 0, 1, 0);
    run4("t3a", 16'h0024, 16'h0016, 0, 1, 16'h0008, 1, 0, 1, 0);
    run4("t3b", 16'h0024, 16'h0016, 1, 1, 16'h0007, 1, 0, 1, 0);
    run4("t4",  16'h0016, 16'h0024, 0, 1, 16'h9992, 0, 0, 1, 0);
    run4("t5",  16'h00A0, 16'h0001, 0, 0, 16'h0000, 0, 1, 0, 0);
    run4("t5b", 16'h0012, 16'h0005, 0, 0, 16'h0017, 0, 0, 1, 0);
    run4("t6bp", 16'h4321, 16'h5678, 1, 0, 16'h0000, 1, 0, 1, 5);
    run4("t6s", 16'h0005, 16'h0005, 0, 1, 16'h0000, 1, 0, 1, 0);
    run4("t6t", 16'h1234, 16'h0000, 0, 0, 16'h1234, 0, 0, 1, 0);

    // Abort a transaction two digits in; the held result must be cleared.
    @(negedge clk);
    a4 = 16'h1234; b4 = 16'h4321; cin4 = 0; sub4 = 0; in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst out_valid", out_valid4, 0);
    chk("rst in_ready", in_ready4, 1);
    chk("rst sum", sum4, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst release in_ready", in_ready4, 1);
    repeat (6) @(posedge clk);
    #1;
    chk("rst no output", out_valid4, 0);
    run4("t6r", 16'h9000, 16'h0001, 0, 1, 16'h8999, 1, 0, 1, 0);

    rand_pair(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
